// File: rtl/mem_access_unit.sv
// RV32 load/store front end: byte/halfword/word requests become whole-word ram accesses,
// with read-modify-write for sub-word stores. Define MAU_MISALIGN_TRAP_EN to reject misaligned accesses.
module mem_access_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic                  ram_write,
   output logic                  ram_read,
   input  logic [DATA_WIDTH-1:0] ram_data_out
);

   typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

   state_t                state, state_nxt;
   logic [2:0]            funct3_q, funct3_nxt;
   logic                  we_q, we_nxt;
   logic [1:0]            off_q, off_nxt;
   logic [15:0]           wdata_q, wdata_nxt;

   logic                  req_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
   logic                  ram_write_nxt, ram_read_nxt;
   logic [DATA_WIDTH-1:0] rsp_rdata_nxt, ram_data_in_nxt;
   logic [ADDR_WIDTH-1:0] ram_address_nxt;

   logic                  illegal, reject;
   logic [1:0]            align_off;

   function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [DATA_WIDTH-1:0] word,
                                                          input logic [2:0] f3,
                                                          input logic [1:0] off);
      logic signed [7:0]            b;
      logic signed [15:0]           h;
      logic signed [DATA_WIDTH-1:0] ext;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  ext = DATA_WIDTH'(b);
         3'b001:  ext = DATA_WIDTH'(h);
         3'b100:  ext = DATA_WIDTH'($unsigned(b));
         3'b101:  ext = DATA_WIDTH'($unsigned(h));
         default: ext = word;
      endcase
      return $unsigned(ext);
   endfunction

   // Only SB (funct3[0]=0) and SH (funct3[0]=1) reach the merge path.
   function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] word,
                                                         input logic [15:0] wd,
                                                         input logic f3_half,
                                                         input logic [1:0] off);
      logic [DATA_WIDTH-1:0] m;
      m = word;
      if (f3_half) begin
         if (off[1]) m[31:16] = wd;
         else        m[15:0]  = wd;
      end else begin
         case (off)
            2'd0:    m[7:0]   = wd[7:0];
            2'd1:    m[15:8]  = wd[7:0];
            2'd2:    m[23:16] = wd[7:0];
            default: m[31:24] = wd[7:0];
         endcase
      end
      return m;
   endfunction

   always_comb begin
      illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_we && req_funct3[2]);
`ifdef MAU_MISALIGN_TRAP_EN
      reject  = illegal ||
                ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
      reject  = illegal;
`endif
      align_off = req_addr[1:0];
      if (req_funct3[1:0] == 2'b01) align_off[0] = 1'b0;
      if (req_funct3[1:0] == 2'b10) align_off     = 2'b00;
   end

   always_comb begin
      state_nxt       = state;
      funct3_nxt      = funct3_q;
      we_nxt          = we_q;
      off_nxt         = off_q;
      wdata_nxt       = wdata_q;
      req_ready_nxt   = 1'b0;
      rsp_valid_nxt   = 1'b0;
      rsp_err_nxt     = 1'b0;
      rsp_rdata_nxt   = '0;
      ram_read_nxt    = 1'b0;
      ram_write_nxt   = 1'b0;
      ram_address_nxt = ram_address;
      ram_data_in_nxt = ram_data_in;
      case (state)
         IDLE: begin
            req_ready_nxt = 1'b1;
            if (req_valid && req_ready) begin
               req_ready_nxt = 1'b0;
               funct3_nxt    = req_funct3;
               we_nxt        = req_we;
               off_nxt       = align_off;
               wdata_nxt     = req_wdata[15:0];
               if (reject) begin
                  state_nxt     = RESP;
                  rsp_valid_nxt = 1'b1;
                  rsp_err_nxt   = 1'b1;
               end else if (req_we && (req_funct3 == 3'b010)) begin
                  state_nxt       = WR;
                  ram_write_nxt   = 1'b1;
                  ram_address_nxt = {2'b00, req_addr[ADDR_WIDTH-1:2]};
                  ram_data_in_nxt = req_wdata;
               end else begin
                  state_nxt       = RD;
                  ram_read_nxt    = 1'b1;
                  ram_address_nxt = {2'b00, req_addr[ADDR_WIDTH-1:2]};
               end
            end
         end
         RD: state_nxt = RD_WAIT;
         RD_WAIT: begin
            if (we_q) begin
               state_nxt       = WR;
               ram_write_nxt   = 1'b1;
               ram_data_in_nxt = store_merge(ram_data_out, wdata_q, funct3_q[0], off_q);
            end else begin
               state_nxt     = RESP;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = load_extract(ram_data_out, funct3_q, off_q);
            end
         end
         WR: begin
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
         end
         default: begin
            state_nxt     = IDLE;
            req_ready_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_rdata   <= '0;
         ram_read    <= 1'b0;
         ram_write   <= 1'b0;
         ram_address <= '0;
         ram_data_in <= '0;
      end else begin
         state       <= state_nxt;
         req_ready   <= req_ready_nxt;
         rsp_valid   <= rsp_valid_nxt;
         rsp_err     <= rsp_err_nxt;
         rsp_rdata   <= rsp_rdata_nxt;
         ram_read    <= ram_read_nxt;
         ram_write   <= ram_write_nxt;
         ram_address <= ram_address_nxt;
         ram_data_in <= ram_data_in_nxt;
      end
   end

   // Request context is plain data and only meaningful after a handshake.
   always_ff @(posedge clk) begin
      funct3_q <= funct3_nxt;
      we_q     <= we_nxt;
      off_q    <= off_nxt;
      wdata_q  <= wdata_nxt;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small synchronous word RAM model.
// Expectations follow MAU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] ram_address;
   logic [31:0] ram_data_in;
   logic        ram_write;
   logic        ram_read;
   logic [31:0] ram_data_out;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] mem [0:63];
   int          wr_cnt   = 0;
   int          rd_cnt   = 0;
   int          both_cnt = 0;
   logic [31:0] last_wa  = '0;
   logic [31:0] last_wd  = '0;

   logic        s_read, s_write;
   logic [31:0] s_addr;
   int          rd0, wr0;

   mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_address(ram_address), .ram_data_in(ram_data_in),
      .ram_write(ram_write), .ram_read(ram_read), .ram_data_out(ram_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_write) begin
         mem[ram_address[5:0]] <= ram_data_in;
         wr_cnt  <= wr_cnt + 1;
         last_wa <= ram_address;
         last_wd <= ram_data_in;
      end
      if (ram_read) begin
         ram_data_out <= mem[ram_address[5:0]];
         rd_cnt       <= rd_cnt + 1;
      end
      if (ram_read && ram_write) both_cnt <= both_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check_bit({tag, "_ready"}, req_ready, 1'b1);
      check_bit({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      check({tag, "_rdata"}, rsp_rdata, 32'h0);
      check_bit({tag, "_err"}, rsp_err, 1'b0);
      check_bit({tag, "_ram_read"}, ram_read, 1'b0);
      check_bit({tag, "_ram_write"}, ram_write, 1'b0);
      check({tag, "_ram_addr"}, ram_address, 32'h0);
      check({tag, "_ram_din"}, ram_data_in, 32'h0);
   endtask

   // One full transaction; latency is the edge count from the handshake edge to
   // the edge that samples rsp_valid high.
   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_rd, input int exp_wr);
      int lat;
      int r0, w0;
      r0 = rd_cnt;
      w0 = wr_cnt;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      tick();
      req_valid = 1'b0;
      s_read  = ram_read;
      s_write = ram_write;
      s_addr  = ram_address;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_rdata"}, rsp_rdata, exp_rdata);
      check_bit({tag, "_err"}, rsp_err, exp_err);
      tick();
      check_bit({tag, "_ready_after"}, req_ready, 1'b1);
      check({tag, "_nreads"}, rd_cnt - r0, exp_rd);
      check({tag, "_nwrites"}, wr_cnt - w0, exp_wr);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = '0;
      req_wdata  = '0;
      tick();
      tick();
      check_reset("reset");
      rst = 1'b0;
      tick();

      do_req("sw_dead", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, 1);
      check_bit("sw_dead_write_k1", s_write, 1'b1);
      check_bit("sw_dead_read_k1", s_read, 1'b0);
      check("sw_dead_addr_k1", s_addr, 32'h4);
      check("sw_dead_wdata", last_wd, 32'hDEADBEEF);
      do_req("lw_dead", 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1, 0);

      do_req("sw_base", 1'b1, 3'b010, 32'h10, 32'h11223344, 2, 32'h0, 1'b0, 0, 1);
      do_req("sb_11", 1'b1, 3'b000, 32'h11, 32'h123456AA, 4, 32'h0, 1'b0, 1, 1);
      check("sb_11_merge", last_wd, 32'h1122AA44);
      check("sb_11_waddr", last_wa, 32'h4);
      do_req("lbu_11", 1'b0, 3'b100, 32'h11, 32'h0, 3, 32'h000000AA, 1'b0, 1, 0);
      do_req("lb_11", 1'b0, 3'b000, 32'h11, 32'h0, 3, 32'hFFFFFFAA, 1'b0, 1, 0);
      do_req("lw_merged", 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'h1122AA44, 1'b0, 1, 0);

      do_req("sw_zero", 1'b1, 3'b010, 32'h10, 32'h0, 2, 32'h0, 1'b0, 0, 1);
      do_req("sh_12", 1'b1, 3'b001, 32'h12, 32'h12348001, 4, 32'h0, 1'b0, 1, 1);
      check("sh_12_merge", last_wd, 32'h80010000);
      do_req("lh_12", 1'b0, 3'b001, 32'h12, 32'h0, 3, 32'hFFFF8001, 1'b0, 1, 0);
      do_req("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0, 3, 32'h00008001, 1'b0, 1, 0);
      do_req("lh_10", 1'b0, 3'b001, 32'h10, 32'h0, 3, 32'h00000000, 1'b0, 1, 0);
      do_req("sb_13", 1'b1, 3'b000, 32'h13, 32'h0000005A, 4, 32'h0, 1'b0, 1, 1);
      check("sb_13_merge", last_wd, 32'h5A010000);
      do_req("lb_13", 1'b0, 3'b000, 32'h13, 32'h0, 3, 32'h0000005A, 1'b0, 1, 0);

`ifdef MAU_MISALIGN_TRAP_EN
      do_req("lw_mis", 1'b0, 3'b010, 32'h13, 32'h0, 1, 32'h0, 1'b1, 0, 0);
      check_bit("lw_mis_read_k1", s_read, 1'b0);
      do_req("sh_mis", 1'b1, 3'b001, 32'h11, 32'hFFFF, 1, 32'h0, 1'b1, 0, 0);
`else
      do_req("lw_mis", 1'b0, 3'b010, 32'h13, 32'h0, 3, 32'h5A010000, 1'b0, 1, 0);
      check("lw_mis_addr", s_addr, 32'h4);
      do_req("lhu_mis", 1'b0, 3'b101, 32'h13, 32'h0, 3, 32'h00005A01, 1'b0, 1, 0);
`endif

      do_req("ill_011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0, 0);
      do_req("ill_sbu", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 1, 32'h0, 1'b1, 0, 0);
      do_req("ill_111", 1'b0, 3'b111, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0, 0);
      do_req("lw_after_ill", 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'h5A010000, 1'b0, 1, 0);

      // A second request held on req_valid must wait until the cycle after RESP.
      rd0 = rd_cnt;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h10;
      tick();
      req_funct3 = 3'b100;
      req_addr   = 32'h13;
      check_bit("bp_ready_rd", req_ready, 1'b0);
      check_bit("bp_read_rd", ram_read, 1'b1);
      tick();
      tick();
      check_bit("bp_rsp1_valid", rsp_valid, 1'b1);
      check("bp_rsp1_rdata", rsp_rdata, 32'h5A010000);
      check_bit("bp_ready_resp", req_ready, 1'b0);
      tick();
      check_bit("bp_ready_idle", req_ready, 1'b1);
      check_bit("bp_no_read_idle", ram_read, 1'b0);
      check("bp_reads_mid", rd_cnt - rd0, 1);
      tick();
      req_valid = 1'b0;
      check_bit("bp_read2", ram_read, 1'b1);
      tick();
      tick();
      check_bit("bp_rsp2_valid", rsp_valid, 1'b1);
      check("bp_rsp2_rdata", rsp_rdata, 32'h0000005A);
      tick();
      check("bp_reads_total", rd_cnt - rd0, 2);

      // Reset while an SB sits in RD_WAIT drops the store.
      do_req("sw_20", 1'b1, 3'b010, 32'h20, 32'h11223344, 2, 32'h0, 1'b0, 0, 1);
      wr0 = wr_cnt;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h20;
      req_wdata  = 32'hAA;
      tick();
      req_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check_reset("midrst");
      rst = 1'b0;
      tick();
      check("midrst_no_write", wr_cnt - wr0, 0);
      do_req("lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 3, 32'h11223344, 1'b0, 1, 0);

      check("never_rd_and_wr", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
